// File: rtl/add_image_hls_deadlock_pkg.sv
// Shared types, default sizes and the set-bit scan helper for the add_image
// dataflow deadlock detector.
package add_image_hls_deadlock_pkg;

  // Default sizing for the add_image dataflow region (14 processes).
  localparam int NUM_PROC_DEF = 14;
  localparam int IDX_W_DEF    = 4;
  localparam int CNT_W_DEF    = 16;

  // Widest block vector the scan helper handles; callers zero-extend to this.
  localparam int MAX_PROC     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUSPECT,
    ST_CONFIRMED,
    ST_REPORT,
    ST_DONE
  } dd_state_e;

  // Index of the lowest set bit of vec at position start or above, or -1 if
  // there is none. Scanning downwards leaves the lowest qualifying hit in res.
  function automatic int lowest_set_at_or_above(input logic [MAX_PROC-1:0] vec,
                                                input int                  start);
    int res;
    res = -1;
    for (int i = MAX_PROC - 1; i >= 0; i--) begin
      if (i >= start && vec[i]) begin
        res = i;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/add_image_hls_deadlock_bit_walker.sv
// Combinational walker over the confirmed block snapshot: given the entry
// currently being reported, finds the next blocked process above it and
// flags whether the current entry is the final one.
module add_image_hls_deadlock_bit_walker
  import add_image_hls_deadlock_pkg::*;
#(
  parameter int NUM_PROC = NUM_PROC_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic [NUM_PROC-1:0] snapshot_i,
  input  logic [IDX_W-1:0]    cur_idx_i,
  output logic [IDX_W-1:0]    next_idx_o,
  output logic                last_o
);

  int next_pos;

  // Search strictly above the current entry; no hit means this entry is last.
  always_comb begin
    next_pos   = lowest_set_at_or_above(MAX_PROC'(snapshot_i), int'(cur_idx_i) + 1);
    last_o     = (next_pos < 0);
    next_idx_o = last_o ? cur_idx_i : IDX_W'(next_pos);
  end

endmodule

// File: rtl/add_image_hls_deadlock_detector.sv
// Deadlock detector for the add_image HLS dataflow region. Watches the
// per-process monitor block bits, confirms a deadlock once the same non-zero
// block pattern persists for the programmed number of samples, latches a
// sticky flag plus snapshot, then streams the blocked process indices out
// over a valid/ready report port.
module add_image_hls_deadlock_detector
  import add_image_hls_deadlock_pkg::*;
#(
  parameter int NUM_PROC = NUM_PROC_DEF,
  parameter int IDX_W    = IDX_W_DEF,   // 2**IDX_W must cover NUM_PROC
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [CNT_W-1:0]    confirm_cycles,
  input  logic [NUM_PROC-1:0] proc_block,
  input  logic [NUM_PROC-1:0] proc_idle,
  input  logic                clear,
  output logic                deadlock,
  output logic [NUM_PROC-1:0] block_snapshot,
  output logic                report_valid,
  output logic [IDX_W-1:0]    report_idx,
  output logic                report_last,
  input  logic                report_ready
);

  dd_state_e           state_q, state_d;
  logic [NUM_PROC-1:0] prev_block_q, prev_block_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
  logic                deadlock_q, deadlock_d;
  logic [NUM_PROC-1:0] snapshot_q, snapshot_d;

  logic                sample_active;
  logic [CNT_W-1:0]    confirm_limit;
  logic [IDX_W-1:0]    first_idx;
  logic [IDX_W-1:0]    walk_next_idx;
  logic                walk_last;
  logic                handshake;

  add_image_hls_deadlock_bit_walker #(
    .NUM_PROC (NUM_PROC),
    .IDX_W    (IDX_W)
  ) u_bit_walker (
    .snapshot_i (snapshot_q),
    .cur_idx_i  (cur_idx_q),
    .next_idx_o (walk_next_idx),
    .last_o     (walk_last)
  );

  // A sample is suspicious only while enabled, something is blocked and the
  // region is not simply idle as a whole.
  always_comb begin
    sample_active = enable && (|proc_block) && !(&proc_idle);
    // A zero threshold behaves like one: confirm once cnt reaches C-1.
    confirm_limit = (confirm_cycles == '0) ? '0 : confirm_cycles - CNT_W'(1);
    first_idx     = IDX_W'(lowest_set_at_or_above(MAX_PROC'(snapshot_q), 0));
  end

  // Report port: entries are only presented in REPORT; zero elsewhere.
  always_comb begin
    report_valid   = (state_q == ST_REPORT);
    report_idx     = report_valid ? cur_idx_q : '0;
    report_last    = report_valid && walk_last;
    handshake      = report_valid && report_ready;
    deadlock       = deadlock_q;
    block_snapshot = snapshot_q;
  end

  // Next-state logic: persistence tracking, confirmation and report walk.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned; that is what keeps this block free of latches.
    state_d      = state_q;
    prev_block_d = prev_block_q;
    cnt_d        = cnt_q;
    cur_idx_d    = cur_idx_q;
    deadlock_d   = deadlock_q;
    snapshot_d   = snapshot_q;

    if (clear) begin
      // Clear wins over a same-cycle handshake and any pending detection.
      state_d      = ST_IDLE;
      prev_block_d = '0;
      cnt_d        = '0;
      cur_idx_d    = '0;
      deadlock_d   = 1'b0;
      snapshot_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (sample_active) begin
            state_d      = ST_SUSPECT;
            cnt_d        = CNT_W'(1);
            prev_block_d = proc_block;
          end
        end

        ST_SUSPECT: begin
          if (!sample_active) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (proc_block != prev_block_q) begin
            // Pattern moved: the region is making progress, restart the run.
            cnt_d        = CNT_W'(1);
            prev_block_d = proc_block;
          end else if (cnt_q >= confirm_limit) begin
            state_d    = ST_CONFIRMED;
            deadlock_d = 1'b1;
            snapshot_d = proc_block;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_CONFIRMED: begin
          cur_idx_d = first_idx;
          state_d   = ST_REPORT;
        end

        ST_REPORT: begin
          if (handshake) begin
            if (walk_last) begin
              state_d = ST_DONE;
            end else begin
              cur_idx_d = walk_next_idx;
            end
          end
        end

        ST_DONE: begin
          // Result is sticky until clear or reset.
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_block_q <= '0;
      cnt_q        <= '0;
      cur_idx_q    <= '0;
      deadlock_q   <= 1'b0;
      snapshot_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_block_q <= prev_block_d;
      cnt_q        <= cnt_d;
      cur_idx_q    <= cur_idx_d;
      deadlock_q   <= deadlock_d;
      snapshot_q   <= snapshot_d;
    end
  end

endmodule
